// File: rtl/encrypt_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : encrypt_arbiter_if
//  Description : Bundle of the requester-side and core-side signals of the
//                Encrypt arbiter. The slave modport is the arbiter's view; the
//                master modport is the environment (requesters plus core).
//  Revision    : 1.0  initial release
// ============================================================================
interface encrypt_arbiter_if #(
    parameter int NREQ = 4
);
    // requester side
    logic [NREQ-1:0]     req;
    logic [NREQ*192-1:0] req_k;
    logic [NREQ*128-1:0] req_s;
    logic [NREQ*128-1:0] req_a;
    logic [NREQ*128-1:0] req_nonce;
    logic [NREQ*128-1:0] req_p;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     rsp_valid;
    logic [127:0]        rsp_c;
    logic                rsp_tag;
    logic                rsp_err;
    logic                busy;
    // core side
    logic                core_rst;
    logic                core_start;
    logic [191:0]        core_k;
    logic [127:0]        core_s;
    logic [127:0]        core_a;
    logic [127:0]        core_nonce;
    logic [127:0]        core_p;
    logic                core_done;
    logic [127:0]        core_c;
    logic                core_tag;

    modport slave (
        input  req, req_k, req_s, req_a, req_nonce, req_p,
        output gnt, rsp_valid, rsp_c, rsp_tag, rsp_err, busy,
        output core_rst, core_start, core_k, core_s, core_a, core_nonce, core_p,
        input  core_done, core_c, core_tag
    );

    modport master (
        output req, req_k, req_s, req_a, req_nonce, req_p,
        input  gnt, rsp_valid, rsp_c, rsp_tag, rsp_err, busy,
        input  core_rst, core_start, core_k, core_s, core_a, core_nonce, core_p,
        output core_done, core_c, core_tag
    );
endinterface
`default_nettype wire

// File: rtl/encrypt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : encrypt_arbiter
//  Description : Round-robin scheduler sharing one Encrypt AEAD core among
//                NREQ requesters. Captures the winner's operands, runs the
//                core, and returns C/TAG (or a timeout error) to the winner.
//  Revision    : 1.0  initial release
// ============================================================================
module encrypt_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    encrypt_arbiter_if.slave  bus
);

    localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit c_TMO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_RESP  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_PW-1:0]   r_rr_ptr;
    logic [c_TW-1:0]   r_timer;

    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [127:0]      r_rsp_c;
    logic              r_rsp_tag;
    logic              r_rsp_err;
    logic              r_busy;
    logic              r_core_rst;
    logic              r_core_start;
    logic [191:0]      r_core_k;
    logic [127:0]      r_core_s;
    logic [127:0]      r_core_a;
    logic [127:0]      r_core_nonce;
    logic [127:0]      r_core_p;

    logic [c_PW-1:0]   w_win_idx;
    logic [c_PW-1:0]   w_cand_idx;
    logic              w_win_found;
    logic [NREQ-1:0]   w_win_oh;
    logic [NREQ-1:0]   w_cur_oh;
    logic              w_tmo;
    logic              w_grant;
    logic              w_finish;
    logic              w_abort;

    // Per-requester operand slices, so the capture mux indexes a small array
    logic [191:0]      w_req_k     [NREQ];
    logic [127:0]      w_req_s     [NREQ];
    logic [127:0]      w_req_a     [NREQ];
    logic [127:0]      w_req_nonce [NREQ];
    logic [127:0]      w_req_p     [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_req_k[gi]     = bus.req_k[gi*192 +: 192];
            assign w_req_s[gi]     = bus.req_s[gi*128 +: 128];
            assign w_req_a[gi]     = bus.req_a[gi*128 +: 128];
            assign w_req_nonce[gi] = bus.req_nonce[gi*128 +: 128];
            assign w_req_p[gi]     = bus.req_p[gi*128 +: 128];
        end
    endgenerate

    // Round-robin search starting after the last winner; scanning from the
    // farthest candidate down lets the nearest set request overwrite last.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand_idx = c_PW'((int'(r_rr_ptr) + k) % NREQ);
            if (bus.req[w_cand_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand_idx;
            end
        end
    end

    assign w_win_oh = NREQ'(1) << w_win_idx;
    assign w_cur_oh = NREQ'(1) << r_rr_ptr;
    assign w_tmo    = c_TMO_EN && (r_timer == c_TMO_LAST);
    assign w_grant  = (r_state == S_IDLE) && w_win_found;
    // done takes priority over a timeout landing on the same edge
    assign w_finish = (r_state == S_RUN) && bus.core_done;
    assign w_abort  = (r_state == S_RUN) && !bus.core_done && w_tmo;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win_found) w_state_nxt = S_RUN;
            S_RUN: begin
                if (bus.core_done) w_state_nxt = S_RESP;
                else if (w_tmo)    w_state_nxt = S_ABORT;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Last-winner pointer and RUN-cycle timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= c_PW'(NREQ - 1);
            r_timer  <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_win_idx;
            r_timer  <= '0;
        end else if ((r_state == S_RUN) && !bus.core_done) begin
            r_timer  <= r_timer + c_TW'(1);
        end
    end

    // Core drive: operands captured at grant and held; start held through RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_rst   <= 1'b1;
            r_core_start <= 1'b0;
            r_core_k     <= '0;
            r_core_s     <= '0;
            r_core_a     <= '0;
            r_core_nonce <= '0;
            r_core_p     <= '0;
        end else begin
            r_core_rst <= w_abort;
            if (w_grant) begin
                r_core_start <= 1'b1;
                r_core_k     <= w_req_k[w_win_idx];
                r_core_s     <= w_req_s[w_win_idx];
                r_core_a     <= w_req_a[w_win_idx];
                r_core_nonce <= w_req_nonce[w_win_idx];
                r_core_p     <= w_req_p[w_win_idx];
            end else if (w_finish || w_abort) begin
                r_core_start <= 1'b0;
            end
        end
    end

    // Response pulse to the current owner; C/TAG hold until the next response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_c     <= '0;
            r_rsp_tag   <= 1'b0;
        end else begin
            r_rsp_valid <= (w_finish || w_abort) ? w_cur_oh : '0;
            r_rsp_err   <= w_abort;
            if (w_finish) begin
                r_rsp_c   <= bus.core_c;
                r_rsp_tag <= bus.core_tag;
            end else if (w_abort) begin
                r_rsp_c   <= '0;
                r_rsp_tag <= 1'b0;
            end
        end
    end

    // Grant pulse and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_gnt  <= w_grant ? w_win_oh : '0;
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_c      = r_rsp_c;
    assign bus.rsp_tag    = r_rsp_tag;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = r_busy;
    assign bus.core_rst   = r_core_rst;
    assign bus.core_start = r_core_start;
    assign bus.core_k     = r_core_k;
    assign bus.core_s     = r_core_s;
    assign bus.core_a     = r_core_a;
    assign bus.core_nonce = r_core_nonce;
    assign bus.core_p     = r_core_p;

endmodule
`default_nettype wire

// File: tb/tb_encrypt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encrypt_arbiter
//  Description : Directed plus randomized bench for encrypt_arbiter with a
//                stand-in Encrypt core and a round-robin reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encrypt_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   last_w;

    logic [191:0] op_k [NREQ];
    logic [127:0] op_s [NREQ];
    logic [127:0] op_a [NREQ];
    logic [127:0] op_n [NREQ];
    logic [127:0] op_p [NREQ];

    encrypt_arbiter_if #(.NREQ(NREQ)) bus ();

    encrypt_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stand-in for the Encrypt transform: any fixed function of all operands
    function automatic logic [127:0] enc_c(input logic [191:0] k, input logic [127:0] s,
                                           input logic [127:0] a, input logic [127:0] n,
                                           input logic [127:0] p);
        return p ^ k[127:0] ^ {k[191:128], k[191:128]} ^ {s[63:0], s[127:64]} ^ (a + 128'd1) ^ ~n;
    endfunction

    function automatic logic enc_tag(input logic [191:0] k, input logic [127:0] p);
        return (^k) ^ p[0] ^ p[127];
    endfunction

    // Round-robin rule: first requester after the last winner, wrapping
    function automatic int pick(input logic [NREQ-1:0] m);
        for (int off = 1; off <= NREQ; off++)
            if (m[(last_w + off) % NREQ]) return (last_w + off) % NREQ;
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_k[i*192 +: 192]   = op_k[i];
            bus.req_s[i*128 +: 128]   = op_s[i];
            bus.req_a[i*128 +: 128]   = op_a[i];
            bus.req_nonce[i*128 +: 128] = op_n[i];
            bus.req_p[i*128 +: 128]   = op_p[i];
        end
    endtask

    task automatic rand_op(input int i);
        op_k[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        op_s[i] = {$urandom, $urandom, $urandom, $urandom};
        op_a[i] = {$urandom, $urandom, $urandom, $urandom};
        op_n[i] = {$urandom, $urandom, $urandom, $urandom};
        op_p[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One job: caller is at posedge+1 with the DUT idle. done_lat is the RUN
    // cycle index (timer value) on which done is presented; >= TMO times out.
    task automatic run_job(input logic [NREQ-1:0] mask, input int done_lat,
                           input int exp_w, input bit rnd);
        int              w;
        int              j;
        bit              sent;
        logic [NREQ-1:0] oh;
        logic [127:0]    exp_c;
        logic            exp_tag;
        logic [191:0]    cap_k;
        logic [127:0]    cap_p;
        for (int i = 0; i < NREQ; i++)
            if (rnd && mask[i] && !bus.req[i]) rand_op(i);
        bus.req = mask;
        pack_ops();
        w  = pick(mask);
        oh = NREQ'(1) << w;
        @(posedge clk); #1;
        chk("gnt", bus.gnt, oh);
        if (exp_w >= 0) chk("gnt_order", bus.gnt, NREQ'(1) << exp_w);
        chk("start_at_gnt", bus.core_start, 1'b1);
        chk("busy_at_gnt", bus.busy, 1'b1);
        chk("core_k", bus.core_k, op_k[w]);
        chk("core_s", bus.core_s, op_s[w]);
        chk("core_a", bus.core_a, op_a[w]);
        chk("core_nonce", bus.core_nonce, op_n[w]);
        chk("core_p", bus.core_p, op_p[w]);
        chk("rsp_valid_at_gnt", bus.rsp_valid, '0);
        last_w  = w;
        cap_k   = op_k[w];
        cap_p   = op_p[w];
        exp_c   = enc_c(op_k[w], op_s[w], op_a[w], op_n[w], op_p[w]);
        exp_tag = enc_tag(op_k[w], op_p[w]);
        // winner drops req and may change its operands immediately
        bus.req[w] = 1'b0;
        rand_op(w);
        pack_ops();
        j    = 0;
        sent = 1'b0;
        while (!sent && j < TMO) begin
            if (j > 0) begin
                chk("start_held", bus.core_start, 1'b1);
                chk("gnt_once", bus.gnt, '0);
                chk("rsp_in_run", bus.rsp_valid, '0);
                chk("k_stable", bus.core_k, cap_k);
                chk("p_stable", bus.core_p, cap_p);
            end
            if (j == done_lat) begin
                sent          = 1'b1;
                bus.core_done = 1'b1;
                bus.core_c    = enc_c(bus.core_k, bus.core_s, bus.core_a, bus.core_nonce, bus.core_p);
                bus.core_tag  = enc_tag(bus.core_k, bus.core_p);
            end
            @(posedge clk); #1;
            j++;
        end
        bus.core_done = 1'b0;
        bus.core_c    = {$urandom, $urandom, $urandom, $urandom};
        bus.core_tag  = 1'($urandom);
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("core_start_off", bus.core_start, 1'b0);
        chk("busy_resp", bus.busy, 1'b1);
        if (sent) begin
            chk("rsp_c", bus.rsp_c, exp_c);
            chk("rsp_tag", bus.rsp_tag, exp_tag);
            chk("rsp_err", bus.rsp_err, 1'b0);
            chk("core_rst_resp", bus.core_rst, 1'b0);
        end else begin
            chk("abort_c", bus.rsp_c, '0);
            chk("abort_tag", bus.rsp_tag, 1'b0);
            chk("abort_err", bus.rsp_err, 1'b1);
            chk("abort_core_rst", bus.core_rst, 1'b1);
        end
        @(posedge clk); #1;
        chk("rsp_pulse_end", bus.rsp_valid, '0);
        chk("err_clear", bus.rsp_err, 1'b0);
        chk("core_rst_clear", bus.core_rst, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("rsp_c_hold", bus.rsp_c, sent ? exp_c : 128'd0);
    endtask

    initial begin
        int w;
        checks        = 0;
        errors        = 0;
        last_w        = NREQ - 1;
        clk           = 1'b0;
        rst           = 1'b0;
        bus.req       = '0;
        bus.core_done = 1'b0;
        bus.core_c    = '0;
        bus.core_tag  = 1'b0;
        for (int i = 0; i < NREQ; i++) rand_op(i);
        pack_ops();

        // reset state
        #12;
        chk("rst_gnt", bus.gnt, '0);
        chk("rst_rsp_valid", bus.rsp_valid, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_core_rst", bus.core_rst, 1'b1);
        chk("rst_start", bus.core_start, 1'b0);
        chk("rst_core_k", bus.core_k, '0);
        chk("rst_rsp_c", bus.rsp_c, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("core_rst_release", bus.core_rst, 1'b0);

        // fairness with all four requesting
        run_job(4'b1111, 2, 0, 1'b1);
        run_job(4'b1111, 0, 1, 1'b1);
        run_job(4'b1111, 3, 2, 1'b1);
        run_job(4'b1111, 1, 3, 1'b1);
        run_job(4'b1111, 5, 0, 1'b1);
        run_job(4'b1111, 0, 1, 1'b1);
        bus.req = '0;
        @(posedge clk); #1;

        // single directed job on requester 0
        op_k[0] = 192'h68656c6c6f206d79206e616d6520697320736f67636f6e21;
        op_s[0] = 128'h726f6265727420697320636f6f6c2021;
        op_a[0] = 128'h646f6e277420726561642074686973;
        op_n[0] = 128'h646f6e277420726561642074686973;
        op_p[0] = 128'h6e2774206465637279707420746873;
        run_job(4'b0001, 2, 0, 1'b0);

        // skip idle bits: pointer at 1, then 3 and 0 requesting
        run_job(4'b0010, 1, 1, 1'b1);
        run_job(4'b1001, 1, 3, 1'b1);
        run_job(4'b1001, 1, 0, 1'b1);
        bus.req = '0;

        // timeout, then done exactly on the last timer value
        run_job(4'b0100, 100, 2, 1'b1);
        run_job(4'b0100, TMO - 1, 2, 1'b1);

        // done while idle is ignored
        bus.core_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_done_busy", bus.busy, 1'b0);
            chk("idle_done_rsp", bus.rsp_valid, '0);
        end
        bus.core_done = 1'b0;

        // randomized jobs, some of which time out
        for (int n = 0; n < 12; n++)
            run_job(NREQ'($urandom_range(1, 15)), $urandom_range(0, 9), -1, 1'b1);
        bus.req = '0;
        @(posedge clk); #1;

        // asynchronous reset in the middle of RUN
        rand_op(2);
        pack_ops();
        bus.req = 4'b0100;
        w = pick(bus.req);
        @(posedge clk); #1;
        chk("pre_rst_gnt", bus.gnt, NREQ'(1) << w);
        bus.req = '0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_start", bus.core_start, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_core_rst", bus.core_rst, 1'b1);
        chk("arst_core_k", bus.core_k, '0);
        chk("arst_core_p", bus.core_p, '0);
        chk("arst_rsp_c", bus.rsp_c, '0);
        chk("arst_rsp_valid", bus.rsp_valid, '0);
        @(posedge clk); #1;
        chk("arst_hold_core_rst", bus.core_rst, 1'b1);
        chk("arst_no_rsp", bus.rsp_valid, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_release", bus.core_rst, 1'b0);
        chk("arst_no_rsp2", bus.rsp_valid, '0);
        last_w = NREQ - 1;
        run_job(4'b1111, 1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
